// File: rtl/haraka_s_pkg.sv
// Shared constants, FSM encoding and the last-word byte mask helper for the
// Haraka-S sponge controller.
package haraka_s_pkg;

  localparam int unsigned STATE_W    = 512;
  localparam int unsigned RATE_W     = 256;
  localparam int unsigned RATE_BYTES = 32;
  localparam int unsigned WORD_W     = 64;

  localparam logic [7:0] PAD_FIRST = 8'h1F;
  localparam logic [7:0] PAD_LAST  = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABSORB,
    ST_PAD,
    ST_PERM_ABS,
    ST_PERM_FIN,
    ST_SQUEEZE,
    ST_PERM_SQ
  } fsm_e;

  // MSB-first mask keeping the first n bytes of a word; n above 8 means 8.
  function automatic logic [WORD_W-1:0] byte_mask(input logic [3:0] n);
    logic [3:0] nc;
    nc = (n > 4'd8) ? 4'd8 : n;
    return ~({WORD_W{1'b1}} >> {nc, 3'b000});
  endfunction

endpackage

// File: rtl/haraka_s_pad.sv
// Haraka-S padding of one rate block: byte p ^= 0x1F, byte 31 ^= 0x80.
// Byte j of the rate lives at rate[255-8j -: 8]; p=31 yields 0x9F.
module haraka_s_pad
  import haraka_s_pkg::*;
(
  input  logic [RATE_W-1:0] rate_i,
  input  logic [4:0]        p_i,
  output logic [RATE_W-1:0] rate_o
);

  logic [RATE_W-1:0] first_pat;
  logic [RATE_W-1:0] last_pat;

  // Place the 0x1F marker at byte p and the 0x80 terminator at byte 31.
  always_comb begin
    first_pat = {PAD_FIRST, {(RATE_W-8){1'b0}}} >> {p_i, 3'b000};
    last_pat  = {{(RATE_W-8){1'b0}}, PAD_LAST};
    rate_o    = rate_i ^ first_pat ^ last_pat;
  end

endmodule

// File: rtl/haraka_s_sponge_ctrl.sv
// Haraka-S sponge controller: absorbs 64-bit words into a 512-bit state,
// pads, drives the permutation core and squeezes 256-bit digest blocks.
// Optional feature macro: HARAKA_S_XOF_EN (multi-block squeeze, OUT_BLOCKS).
module haraka_s_sponge_ctrl
  import haraka_s_pkg::*;
#(
  parameter int unsigned OUT_BLOCKS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               msg_valid,
  output logic               msg_ready,
  input  logic [WORD_W-1:0]  msg_data,
  input  logic               msg_last,
  input  logic [3:0]         msg_bytes,
  output logic               perm_start,
  output logic [STATE_W-1:0] perm_in,
  input  logic               perm_done,
  input  logic [STATE_W-1:0] perm_out,
  output logic               dig_valid,
  input  logic               dig_ready,
  output logic [RATE_W-1:0]  dig_data,
  output logic               dig_last,
  output logic               busy
);

  if (OUT_BLOCKS < 1 || OUT_BLOCKS > 255) begin : g_out_blocks_range
    $error("OUT_BLOCKS must be in 1..255");
  end

  fsm_e               fsm_q, fsm_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [1:0]         w_q, w_d;
  logic [5:0]         p_q, p_d;
  logic               ret_pad_q, ret_pad_d;
  logic               start_q, start_d;
  logic               live_q;

`ifdef HARAKA_S_XOF_EN
  localparam logic [7:0] LAST_BLK = 8'(OUT_BLOCKS - 1);
  logic [7:0] blk_q, blk_d;
`endif

  logic               word_acc;
  logic [1:0]         w_idx;
  logic [5:0]         p_base;
  logic [STATE_W-1:0] absorb_base;
  logic [3:0]         last_bytes;
  logic [WORD_W-1:0]  word_mask;
  logic [STATE_W-1:0] word_vec;
  logic [RATE_W-1:0]  padded_rate;

  // IDLE absorbs its first word onto a zero state at word/byte index 0.
  always_comb begin
    word_acc    = msg_valid && msg_ready;
    w_idx       = (fsm_q == ST_ABSORB) ? w_q : 2'd0;
    p_base      = (fsm_q == ST_ABSORB) ? p_q : 6'd0;
    absorb_base = (fsm_q == ST_ABSORB) ? state_q : '0;
    last_bytes  = (msg_bytes > 4'd8) ? 4'd8 : msg_bytes;
    word_mask   = msg_last ? byte_mask(msg_bytes) : '1;
    word_vec    = {msg_data & word_mask, {(STATE_W-WORD_W){1'b0}}} >> {w_idx, 6'b000000};
  end

  haraka_s_pad u_pad (
    .rate_i (state_q[STATE_W-1 -: RATE_W]),
    .p_i    (p_q[4:0]),
    .rate_o (padded_rate)
  );

  // Handshake-facing outputs decoded from the registered state.
  always_comb begin
    msg_ready  = (fsm_q == ST_ABSORB) || ((fsm_q == ST_IDLE) && live_q);
    perm_start = start_q;
    perm_in    = state_q;
    busy       = (fsm_q != ST_IDLE);
    dig_valid  = (fsm_q == ST_SQUEEZE);
    dig_data   = dig_valid ? state_q[STATE_W-1 -: RATE_W] : '0;
`ifdef HARAKA_S_XOF_EN
    dig_last   = dig_valid && (blk_q == LAST_BLK);
`else
    dig_last   = dig_valid;
`endif
  end

  // Next-state logic: absorb, pad, permutation handshakes and squeeze.
  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    w_d       = w_q;
    p_d       = p_q;
    ret_pad_d = ret_pad_q;
    start_d   = 1'b0;
`ifdef HARAKA_S_XOF_EN
    blk_d     = blk_q;
`endif
    case (fsm_q)
      ST_IDLE, ST_ABSORB: begin
        if (fsm_q == ST_IDLE) begin
          state_d   = '0;
          w_d       = '0;
          p_d       = '0;
          ret_pad_d = 1'b0;
`ifdef HARAKA_S_XOF_EN
          blk_d     = '0;
`endif
        end
        if (word_acc) begin
          state_d = absorb_base ^ word_vec;
          if (msg_last) begin
            p_d   = p_base + {2'b00, last_bytes};
            w_d   = '0;
            fsm_d = ST_PAD;
          end else begin
            p_d = p_base + 6'd8;
            if (w_idx == 2'd3) begin
              w_d     = '0;
              fsm_d   = ST_PERM_ABS;
              start_d = 1'b1;
            end else begin
              w_d   = w_idx + 2'd1;
              fsm_d = ST_ABSORB;
            end
          end
        end
      end
      ST_PAD: begin
        // A completely full block is permuted first, then padding goes
        // into a fresh block on the return to PAD.
        if (p_q == 6'd32) begin
          ret_pad_d = 1'b1;
          fsm_d     = ST_PERM_ABS;
          start_d   = 1'b1;
        end else begin
          state_d[STATE_W-1 -: RATE_W] = padded_rate;
          fsm_d   = ST_PERM_FIN;
          start_d = 1'b1;
        end
      end
      ST_PERM_ABS: begin
        if (perm_done) begin
          state_d   = perm_out;
          p_d       = '0;
          ret_pad_d = 1'b0;
          fsm_d     = ret_pad_q ? ST_PAD : ST_ABSORB;
        end
      end
      ST_PERM_FIN: begin
        if (perm_done) begin
          state_d = perm_out;
          fsm_d   = ST_SQUEEZE;
        end
      end
      ST_SQUEEZE: begin
        if (dig_ready) begin
          if (dig_last) begin
            state_d = '0;
            fsm_d   = ST_IDLE;
          end
`ifdef HARAKA_S_XOF_EN
          else begin
            blk_d   = blk_q + 8'd1;
            fsm_d   = ST_PERM_SQ;
            start_d = 1'b1;
          end
`endif
        end
      end
`ifdef HARAKA_S_XOF_EN
      ST_PERM_SQ: begin
        if (perm_done) begin
          state_d = perm_out;
          fsm_d   = ST_SQUEEZE;
        end
      end
`endif
      default: begin
        fsm_d   = ST_IDLE;
        state_d = '0;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q     <= ST_IDLE;
      state_q   <= '0;
      w_q       <= '0;
      p_q       <= '0;
      ret_pad_q <= 1'b0;
      start_q   <= 1'b0;
      live_q    <= 1'b0;
`ifdef HARAKA_S_XOF_EN
      blk_q     <= '0;
`endif
    end else begin
      fsm_q     <= fsm_d;
      state_q   <= state_d;
      w_q       <= w_d;
      p_q       <= p_d;
      ret_pad_q <= ret_pad_d;
      start_q   <= start_d;
      live_q    <= 1'b1;
`ifdef HARAKA_S_XOF_EN
      blk_q     <= blk_d;
`endif
    end
  end

endmodule
